// File: rtl/data_mem_if_pkg.sv
// Shared types and constants for the data-memory bus interface.
//   mem_if_state_e : transaction FSM state encoding
//   MaskWidth      : byte-enable width of the data bus
package mem_if_pkg;

    localparam int MaskWidth = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_if_state_e;

endpackage

// File: rtl/data_mem_if_if.sv
// Data-memory bus bundle: req/gnt request phase plus rvalid response phase.
//   master : drives mem_req/mem_we/mem_be/mem_addr/mem_wdata, receives
//            mem_gnt/mem_rvalid/mem_rdata (the load/store unit side)
//   slave  : the memory side of the same wires
interface data_mem_if_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic                               mem_req;
    logic                               mem_we;
    logic [mem_if_pkg::MaskWidth-1:0]   mem_be;
    logic [AddrWidth-1:0]               mem_addr;
    logic [DataWidth-1:0]               mem_wdata;
    logic                               mem_gnt;
    logic                               mem_rvalid;
    logic [DataWidth-1:0]               mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/data_mem_if_txn_timer.sv
// Transaction watchdog counter.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : restart the count at zero (start of a transaction)
//   enable   : count this cycle (transaction in flight)
//   expired  : count has reached Limit-1, the last cycle allowed in flight
// The counter saturates at Limit so a load granted in its final allowed
// cycle still reports expired while it waits for data.
module txn_timer #(
    parameter int Limit = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(Limit + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != W'(Limit))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt >= W'(Limit - 1));

endmodule

// File: rtl/data_mem_if.sv
// Data-memory bus interface downstream of memory_stage.
// Captures one load/store request, runs req/gnt then (for loads) rvalid on
// the data bus, stalls the pipeline while the access is in flight and
// aborts with bus_err when the watchdog expires.
//   clk, rst      : clock, asynchronous active-low reset
//   request       : access request from memory_stage
//   we_re         : 1 = store, 0 = load
//   mask          : byte enables
//   address       : byte address
//   store_data    : lane-aligned store data
//   stall         : hold the upstream pipeline
//   wrap_load_in  : last load data (registered, 0 after a timed-out load)
//   data_valid    : one-cycle pulse, load data valid
//   done          : one-cycle pulse, transaction finished (ok or error)
//   bus_err       : one-cycle pulse alongside done on timeout
//   dbus          : data-memory bus (master side)
module data_mem_if
    import mem_if_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 request,
    input  logic                 we_re,
    input  logic [MaskWidth-1:0] mask,
    input  logic [AddrWidth-1:0] address,
    input  logic [DataWidth-1:0] store_data,
    output logic                 stall,
    output logic [DataWidth-1:0] wrap_load_in,
    output logic                 data_valid,
    output logic                 done,
    output logic                 bus_err,
    data_mem_if_if.master        dbus
);

    mem_if_state_e        state;
    logic                 hold_we;
    logic [MaskWidth-1:0] hold_be;
    logic [AddrWidth-1:0] hold_addr;
    logic [DataWidth-1:0] hold_wdata;
    logic                 err_q;
    logic                 expired;
    logic                 in_req;

    // Mask that clears the byte-offset bits to form a word address.
    localparam logic [AddrWidth-1:0] WordMask = {{(AddrWidth-2){1'b1}}, 2'b00};

    txn_timer #(.Limit(TimeoutCycles)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == ST_IDLE) && request),
        .enable  ((state == ST_REQ) || (state == ST_WAIT)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            hold_we      <= 1'b0;
            hold_be      <= '0;
            hold_addr    <= '0;
            hold_wdata   <= '0;
            err_q        <= 1'b0;
            wrap_load_in <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (request) begin
                        hold_we    <= we_re;
                        hold_be    <= mask;
                        hold_addr  <= address;
                        hold_wdata <= store_data;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A grant in the expiring cycle still counts as progress.
                    if (dbus.mem_gnt) begin
                        state <= hold_we ? ST_DONE : ST_WAIT;
                    end else if (expired) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                        if (!hold_we) wrap_load_in <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dbus.mem_rvalid) begin
                        wrap_load_in <= dbus.mem_rdata;
                        state        <= ST_DONE;
                    end else if (expired) begin
                        err_q        <= 1'b1;
                        wrap_load_in <= '0;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The request still visible here belongs to the finishing
                    // instruction, so it is deliberately not recaptured.
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs decode straight from the state register so that an async
    // reset drops them in the same cycle.
    assign in_req         = (state == ST_REQ);
    assign dbus.mem_req   = in_req;
    assign dbus.mem_we    = in_req & hold_we;
    assign dbus.mem_be    = in_req ? hold_be : '0;
    assign dbus.mem_addr  = in_req ? (hold_addr & WordMask) : '0;
    assign dbus.mem_wdata = in_req ? hold_wdata : '0;

    assign stall      = ((state == ST_IDLE) & request) | (state == ST_REQ) | (state == ST_WAIT);
    assign done       = (state == ST_DONE);
    assign bus_err    = done & err_q;
    assign data_valid = done & ~hold_we & ~err_q;

endmodule
